// File: rtl/probe_capture_reader.sv
// -----------------------------------------------------------------------------
// probe_capture_reader
//
// Readout side of the probe capture path. After arm and a qualified trigger,
// DEPTH consecutive WIDTH-bit probe samples are written into an internal
// buffer. The buffer is then drained as OUT_W-bit words over a valid/ready
// stream, LSB word of each sample first. No new samples are taken until the
// buffer has been fully read out or the capture is aborted.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   arm        start request, honoured only in IDLE
//   abort      synchronous cancel, wins over everything else
//   trig       trigger qualifier, sampled together with sample_en
//   sample_en  sample_in is valid this cycle
//   sample_in  WIDTH-bit probe sample
//   rd_data    OUT_W-bit readout word, 0 when rd_valid=0
//   rd_valid   readout word available (the whole READOUT state)
//   rd_ready   consumer accepts the word
//   rd_last    final word of the capture, only together with rd_valid
//   busy       state is not IDLE
//   state_o    IDLE=0, ARMED=1, CAPTURE=2, READOUT=3
// -----------------------------------------------------------------------------
module probe_capture_reader #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample_in,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             busy,
  output logic [1:0]       state_o
);

  localparam int WPS    = WIDTH / OUT_W;                 // words per sample
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WIDX_W = (WPS > 1) ? $clog2(WPS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t            state_reg;
  logic [PTR_W-1:0]  wptr_reg;
  logic [PTR_W-1:0]  rptr_reg;
  logic [WIDX_W-1:0] widx_reg;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_en;
  logic              last_widx;
  logic              last_rptr;
  logic [WIDTH-1:0]  rd_sample;
  logic [OUT_W-1:0]  rd_words [WPS];

  // wptr is always 0 while ARMED (every path into IDLE clears it), so the
  // trigger sample lands in mem[0] through the same write port.
  assign wr_en = !abort && sample_en &&
                 ((state_reg == ARMED && trig) || state_reg == CAPTURE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_reg] <= sample_in;
    end
  end

  // Readout is an asynchronous read of the buffer so the first word is
  // available in the very first READOUT cycle, with no bubble.
  assign rd_sample = mem[rptr_reg];

  generate
    for (genvar gi = 0; gi < WPS; gi++) begin : g_words
      assign rd_words[gi] = rd_sample[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign last_widx = (widx_reg == WIDX_W'(WPS - 1));
  assign last_rptr = (rptr_reg == PTR_W'(DEPTH - 1));

  // All outputs are decoded from registers only; rd_ready never reaches them.
  assign rd_valid = (state_reg == READOUT);
  assign rd_data  = rd_valid ? rd_words[widx_reg] : '0;
  assign rd_last  = rd_valid && last_rptr && last_widx;
  assign busy     = (state_reg != IDLE);
  assign state_o  = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      widx_reg  <= '0;
    end else if (abort) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      widx_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg <= ARMED;
          end
        end
        ARMED: begin
          if (sample_en && trig) begin
            wptr_reg  <= PTR_W'(1);
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            if (wptr_reg == PTR_W'(DEPTH - 1)) begin
              wptr_reg  <= '0;
              rptr_reg  <= '0;
              widx_reg  <= '0;
              state_reg <= READOUT;
            end else begin
              wptr_reg <= wptr_reg + PTR_W'(1);
            end
          end
        end
        READOUT: begin
          if (rd_ready) begin
            if (last_widx) begin
              widx_reg <= '0;
              if (last_rptr) begin
                rptr_reg  <= '0;
                state_reg <= IDLE;
              end else begin
                rptr_reg <= rptr_reg + PTR_W'(1);
              end
            end else begin
              widx_reg <= widx_reg + WIDX_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_capture_reader.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for probe_capture_reader at default parameters
// (WIDTH=64, DEPTH=16, OUT_W=16 -> 64 words per capture).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_probe_capture_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;
  logic        sample_en = 1'b0;
  logic [63:0] sample_in = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        rd_last;
  logic        busy;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_s [16];

  probe_capture_reader #(.WIDTH(64), .DEPTH(16), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .abort     (abort),
    .trig      (trig),
    .sample_en (sample_en),
    .sample_in (sample_in),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int idx);
    logic [63:0] s;
    s = exp_s[idx / 4];
    return s[(idx % 4) * 16 +: 16];
  endfunction

  function automatic logic [63:0] ramp(input int k);
    return 64'(k) * 64'h0001_0001_0001_0001;
  endfunction

  // Arms from IDLE, discards n_pre untriggered samples, then captures exp_s[]
  // with optional idle (sample_en=0) cycles between samples.
  task automatic capture(input int n_pre, input bit gap, input bit keep_arm);
    arm = 1'b1;
    step();
    arm = keep_arm;
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL arm_to_armed: state_o=%0d expected 1", state_o);
    end
    for (int p = 0; p < n_pre; p++) begin
      sample_en = 1'b1; trig = 1'b0; sample_in = 64'h1111_2222_3333_0000 + 64'(p);
      step();
      n_checks++;
      if (state_o !== 2'd1) begin
        n_fail++;
        $display("FAIL untrig_stays_armed: state_o=%0d expected 1", state_o);
      end
    end
    for (int k = 0; k < 16; k++) begin
      sample_en = 1'b1; trig = (k == 0); sample_in = exp_s[k];
      step();
      n_checks++;
      if (k < 15 && state_o !== 2'd2) begin
        n_fail++;
        $display("FAIL capture_state k=%0d: state_o=%0d expected 2", k, state_o);
      end else if (k == 15 && (state_o !== 2'd3 || rd_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL enter_readout: state_o=%0d rd_valid=%b expected 3/1", state_o, rd_valid);
      end
      if (gap && k < 15) begin
        sample_en = 1'b0; trig = 1'b1; sample_in = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        n_checks++;
        if (state_o !== 2'd2) begin
          n_fail++;
          $display("FAIL stall_state k=%0d: state_o=%0d expected 2", k, state_o);
        end
      end
    end
    sample_en = 1'b0; trig = 1'b0; sample_in = '0;
  endtask

  // pat 0: rd_ready always 1; pat 1: rd_ready 1,0,0,1 repeating.
  task automatic drain(input int pat, input int n_words);
    int          idx = 0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_last = 1'b0;
    while (idx < n_words && cyc < 400) begin
      rd_ready = (pat == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      n_checks++;
      if (rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rd_valid word %0d: got %b expected 1", idx, rd_valid);
      end
      if (prev_stall) begin
        n_checks++;
        if (rd_data !== prev_d || rd_last !== prev_last) begin
          n_fail++;
          $display("FAIL hold word %0d: data=%h last=%b expected %h/%b",
                   idx, rd_data, rd_last, prev_d, prev_last);
        end
      end
      if (rd_ready) begin
        n_checks++;
        if (rd_data !== exp_word(idx) || rd_last !== (idx == 63)) begin
          n_fail++;
          $display("FAIL word %0d: data=%h last=%b expected %h/%b",
                   idx, rd_data, rd_last, exp_word(idx), (idx == 63));
        end
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_d     = rd_data;
        prev_last  = rd_last;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    n_checks++;
    if (idx < n_words) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words expected %0d", idx, n_words);
    end
    if (n_words == 64) begin
      n_checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_drain: rd_valid=%b busy=%b expected 0/0", rd_valid, busy);
      end
      if (pat == 0) begin
        n_checks++;
        if (cyc != 64) begin
          n_fail++;
          $display("FAIL drain_cycles: got %0d expected 64", cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (rd_data !== 16'h0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
        busy !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h valid=%b last=%b busy=%b state=%0d expected all 0",
               rd_data, rd_valid, rd_last, busy, state_o);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: state_o=%0d expected 0", state_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) exp_s[k] = ramp(k);
    capture(0, 1'b0, 1'b0);
    drain(0, 64);
    $display("test_basic done");
  endtask

  task automatic test_trigger_stall();
    exp_s[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int k = 1; k < 16; k++) exp_s[k] = 64'h5000_4000_3000_2000 + ramp(k);
    capture(3, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 16'hDDDD) begin
      n_fail++;
      $display("FAIL first_word: got %h expected DDDD", rd_data);
    end
    drain(0, 64);
    $display("test_trigger_stall done");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 16; k++) exp_s[k] = ramp(k);
    capture(0, 1'b0, 1'b0);
    drain(1, 64);
    $display("test_backpressure done");
  endtask

  task automatic test_abort();
    // Abort in CAPTURE after 5 samples.
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample_en = 1'b1; trig = 1'b1; sample_in = ramp(k + 7);
      step();
    end
    sample_en = 1'b0; trig = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (state_o !== 2'd0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_capture: state=%0d valid=%b data=%h expected 0/0/0",
               state_o, rd_valid, rd_data);
    end
    step(); step();
    n_checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_capture_stays: valid=%b busy=%b expected 0/0", rd_valid, busy);
    end
    // Abort in READOUT after 10 words; abort cycle's word is not transferred.
    for (int k = 0; k < 16; k++) exp_s[k] = 64'h0F0F_0E0E_0D0D_0C0C ^ ramp(k);
    capture(0, 1'b0, 1'b0);
    drain(0, 10);
    rd_ready = 1'b1; abort = 1'b1;
    step();
    rd_ready = 1'b0; abort = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || state_o !== 2'd0 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_readout: valid=%b state=%0d data=%h expected 0/0/0",
               rd_valid, state_o, rd_data);
    end
    for (int k = 0; k < 16; k++) exp_s[k] = 64'h9000_8000_7000_6000 + ramp(k);
    capture(0, 1'b0, 1'b0);
    drain(0, 64);
    $display("test_abort done");
  endtask

  task automatic test_arm_priority();
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL arm_with_abort: state_o=%0d expected 0", state_o);
    end
    // arm held high through capture and readout.
    for (int k = 0; k < 16; k++) exp_s[k] = ~ramp(k);
    capture(0, 1'b0, 1'b1);
    drain(0, 64);
    // arm still high: state went IDLE after the rd_last transfer, now re-arms.
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_after_last: state_o=%0d expected 0", state_o);
    end
    step();
    arm = 1'b0;
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL arm_first_idle: state_o=%0d expected 1", state_o);
    end
    abort = 1'b1; step(); abort = 1'b0;
    $display("test_arm_priority done");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 16; k++) exp_s[k] = ramp(k + 3);
    capture(0, 1'b0, 1'b0);
    drain(0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 16'h0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
        busy !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: data=%h valid=%b last=%b busy=%b state=%0d expected all 0",
               rd_data, rd_valid, rd_last, busy, state_o);
    end
    step();
    rst_n = 1'b1;
    step(); step();
    n_checks++;
    if (state_o !== 2'd0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_release: state_o=%0d valid=%b expected 0/0", state_o, rd_valid);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger_stall();
    test_backpressure();
    test_abort();
    test_arm_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
